// File: rtl/iomem_gpio_irq.sv
// iomem_gpio_irq: memory-mapped GPIO for the picosoc iomem bus.
//   offset 0 OUT  (R/W)  -> gpio_out
//   offset 1 IN   (RO)   synchronised (and optionally debounced) gpio_in
//   offset 2 IEN  (R/W)  per-bit interrupt enable
//   offset 3 PEND (R/W1C) per-bit rising-edge pending flags
// Optional feature macro: GPIO_DEBOUNCE_EN (tick-based 3-sample debounce on
// the input path). Without it the IN register is the synchroniser output.
module iomem_gpio_irq #(
  parameter logic [7:0] BASE_ADDR = 8'h03,
  parameter int         N_OUT     = 8,
  parameter int         N_IN      = 8,
  parameter int         DB_DIV    = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [N_IN-1:0]   gpio_in,
  output logic [N_OUT-1:0]  gpio_out,
  output logic              irq
);

  localparam logic [1:0] OFF_OUT  = 2'd0;
  localparam logic [1:0] OFF_IN   = 2'd1;
  localparam logic [1:0] OFF_IEN  = 2'd2;
  localparam logic [1:0] OFF_PEND = 2'd3;

  logic              ready_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [N_OUT-1:0]  out_q, out_d;
  logic [N_IN-1:0]   ien_q, ien_d;
  logic [N_IN-1:0]   pend_q, pend_d;
  logic              irq_q;
  logic [N_IN-1:0]   sync1_q, sync2_q;
  logic [N_IN-1:0]   db;
  logic [N_IN-1:0]   db_dly_q;
  logic [N_IN-1:0]   rise;

  logic              sel;
  logic              wr;
  logic [1:0]        reg_off;
  logic [31:0]       wmask;
  logic [31:0]       rd_data;

  // Address bits outside the decode and write-data bits above the register
  // widths alias / are ignored by design.
  logic unused_ok;
  assign unused_ok = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata, wmask};

  // Request decode: accept only when not already acknowledging.
  assign sel     = iomem_valid & ~ready_q & (iomem_addr[31:24] == BASE_ADDR);
  assign wr      = sel & (|iomem_wstrb);
  assign reg_off = iomem_addr[3:2];
  assign wmask   = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

  assign rise = db & ~db_dly_q;

  // Read mux: zero-extended view of the addressed register.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    rd_data = '0;
    case (reg_off)
      OFF_OUT:  rd_data = 32'(out_q);
      OFF_IN:   rd_data = 32'(db);
      OFF_IEN:  rd_data = 32'(ien_q);
      OFF_PEND: rd_data = 32'(pend_q);
      default:  rd_data = '0;
    endcase
  end

  // Register next-state: byte-masked writes, W1C pending, rising edges set.
  always_comb begin
    out_d   = out_q;
    ien_d   = ien_q;
    pend_d  = pend_q;
    rdata_d = sel ? rd_data : rdata_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (wr && reg_off == OFF_OUT && wmask[i]) out_d[i] = iomem_wdata[i];
    end
    for (int i = 0; i < N_IN; i++) begin
      if (wr && reg_off == OFF_IEN && wmask[i]) ien_d[i] = iomem_wdata[i];
      if (wr && reg_off == OFF_PEND && wmask[i] && iomem_wdata[i]) pend_d[i] = 1'b0;
    end
    // A new edge in the same cycle as a clear wins.
    pend_d = pend_d | rise;
  end

  // Bus handshake, architectural registers and registered interrupt.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      out_q    <= '0;
      ien_q    <= '0;
      pend_q   <= '0;
      irq_q    <= 1'b0;
      db_dly_q <= '0;
    end else begin
      ready_q  <= sel;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
      ien_q    <= ien_d;
      pend_q   <= pend_d;
      irq_q    <= |(pend_q & ien_q);
      db_dly_q <= db;
    end
  end

  // Two-flop synchroniser for the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int             TW        = $clog2(DB_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(DB_DIV - 1);

  logic [TW-1:0]          tick_cnt_q;
  logic                   tick;
  logic [N_IN-1:0][1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]        stable_q, stable_d;

  assign tick = (tick_cnt_q == TICK_LAST);
  assign db   = stable_q;

  // Free-running sample tick, one pulse every DB_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Per bit: accept a new level after three consecutive differing ticks.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (tick) begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == 2'd2) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = 2'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 2'd1;
          end
        end else begin
          cnt_d[i] = 2'd0;
        end
      end
    end
  end

  // Debounce state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
`else
  // Without debounce the sample-tick period has no effect.
  logic unused_db_div;
  assign unused_db_div = (DB_DIV < 2);
  assign db = sync2_q;
`endif

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign irq         = irq_q;

endmodule
